moa_8x8_sum_checker: RTL and testbench

Self-checking consumer for the 8-operand, 8-bit pipelined adder tree (`moa_8x8p1_tree`). It observes the operand set driven into the tree and computes the expected 11-bit sum. That sum is delayed through a LATENCY-deep valid-tagged pipeline and compared against the tree's `summ` output when it arrives. It reports per-result mismatch pulses, a sticky error, and saturating check and error counters for benches and on-chip BIST.

---
 rtl/moa_8x8_sum_checker.sv | 184 ++++++++++++++++++
 tb/tb_moa_8x8_sum_checker.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moa_8x8_sum_checker.sv
// moa_8x8_sum_checker
//   Self-checking consumer for the 8-operand, 8-bit pipelined adder tree.
//   Computes the expected 11-bit sum of x0..x7 and carries it through a
//   LATENCY-deep valid-tagged delay line. When a tag reaches the last stage,
//   it is compared against the tree's summ. The block reports mismatch
//   pulses, a sticky error flag and saturating check and error counters.
//
//   Optional feature macro: MOA_CHK_HALT_EN
//     When defined, the first mismatch freezes the checker in HALT, which
//     holds the failing pair until clr or reset.
module moa_8x8_sum_checker #(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [7:0]       x0,
    input  logic [7:0]       x1,
    input  logic [7:0]       x2,
    input  logic [7:0]       x3,
    input  logic [7:0]       x4,
    input  logic [7:0]       x5,
    input  logic [7:0]       x6,
    input  logic [7:0]       x7,
    input  logic [10:0]      summ,
    output logic             busy,
    output logic             chk_valid,
    output logic             mismatch,
    output logic [10:0]      exp_summ,
    output logic [10:0]      got_summ,
    output logic             err_sticky,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned DL_W = LATENCY * 11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
`ifdef MOA_CHK_HALT_EN
        , S_HALT = 2'd3
`endif
    } state_e;

    state_e                     state_q;
    logic [LATENCY-1:0]         vld_q, vld_d, vld_sh;
    logic [LATENCY-1:0][10:0]   exp_q, exp_d, exp_sh;
    logic [10:0]                sum_w;
    logic                       halted;
    logic                       cmp_fire;
    logic                       cmp_mis;

    logic                       chk_valid_q;
    logic                       mismatch_q;
    logic [10:0]                exp_summ_q;
    logic [10:0]                got_summ_q;
    logic                       err_sticky_q;
    logic [CNT_W-1:0]           chk_cnt_q;
    logic [CNT_W-1:0]           err_cnt_q;

    // Expected sum, delay-line shift, freeze/clear selection and compare decode
    always_comb begin
        sum_w = 11'(x0) + 11'(x1) + 11'(x2) + 11'(x3)
              + 11'(x4) + 11'(x5) + 11'(x6) + 11'(x7);

`ifdef MOA_CHK_HALT_EN
        halted = (state_q == S_HALT);
`else
        halted = 1'b0;
`endif

        // Stage index 0 is stage 1; index LATENCY-1 is the compare stage.
        vld_sh = (vld_q << 1) | LATENCY'(in_valid);
        exp_sh = (exp_q << 11) | DL_W'(sum_w);

        vld_d = vld_sh;
        exp_d = exp_sh;
        if (clr) begin
            vld_d = '0;
        end else if (halted) begin
            vld_d = vld_q;
            exp_d = exp_q;
        end

        cmp_fire = vld_q[LATENCY-1] && !halted;
        cmp_mis  = (summ != exp_q[LATENCY-1]);
    end

    // Delay line of {valid, expected sum} tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            exp_q <= '0;
        end else begin
            vld_q <= vld_d;
            exp_q <= exp_d;
        end
    end

    // Control FSM with registered compare results, sticky flag and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            chk_valid_q  <= 1'b0;
            mismatch_q   <= 1'b0;
            exp_summ_q   <= '0;
            got_summ_q   <= '0;
            err_sticky_q <= 1'b0;
            chk_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else if (clr) begin
            state_q      <= S_IDLE;
            chk_valid_q  <= 1'b0;
            mismatch_q   <= 1'b0;
            exp_summ_q   <= '0;
            got_summ_q   <= '0;
            err_sticky_q <= 1'b0;
            chk_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            chk_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            if (cmp_fire) begin
                chk_valid_q <= 1'b1;
                mismatch_q  <= cmp_mis;
                exp_summ_q  <= exp_q[LATENCY-1];
                got_summ_q  <= summ;
                if (chk_cnt_q != '1) begin
                    chk_cnt_q <= chk_cnt_q + CNT_W'(1);
                end
                if (cmp_mis) begin
                    err_sticky_q <= 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_q <= err_cnt_q + CNT_W'(1);
                    end
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_q <= S_FILL;
                    end
                end
                S_FILL, S_RUN: begin
`ifdef MOA_CHK_HALT_EN
                    if (cmp_fire && cmp_mis) begin
                        state_q <= S_HALT;
                    end else
`endif
                    // Leaving on an empty next-state line lets busy drop the
                    // cycle after the final comparison, even from FILL.
                    if (vld_sh == '0) begin
                        state_q <= S_IDLE;
                    end else if (cmp_fire) begin
                        state_q <= S_RUN;
                    end
                end
`ifdef MOA_CHK_HALT_EN
                S_HALT: begin
                    state_q <= S_HALT;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign chk_valid  = chk_valid_q;
    assign mismatch   = mismatch_q;
    assign exp_summ   = exp_summ_q;
    assign got_summ   = got_summ_q;
    assign err_sticky = err_sticky_q;
    assign chk_cnt    = chk_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_moa_8x8_sum_checker.sv
// tb_moa_8x8_sum_checker
//   Directed bench for moa_8x8_sum_checker. An ideal 3-cycle adder-tree model
//   drives summ, with an injectable offset. A second instance (CNT_W=4,
//   LATENCY=1, summ tied to 0) exercises counter saturation.
//   Sequences that depend on MOA_CHK_HALT_EN are selected with that macro.
module tb_moa_8x8_sum_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clr, in_valid, in_valid2;
    logic [7:0]  x [8];
    logic [10:0] inj, sum_w, p0, p1, p2, summ;

    logic        busy, chk_valid, mismatch, err_sticky;
    logic [10:0] exp_summ, got_summ;
    logic [15:0] chk_cnt, err_cnt;

    logic        busy2, chk_valid2, mismatch2, err_sticky2;
    logic [10:0] exp_summ2, got_summ2;
    logic [3:0]  chk_cnt2, err_cnt2;

    int checks = 0;
    int errors = 0;
    int npulse = 0;
    int nmis   = 0;

    typedef struct packed {
        logic [10:0] e;
        logic [10:0] g;
        logic        m;
    } exp_t;
    exp_t expq [$];

    typedef struct packed {
        logic [63:0] xs;
        logic [10:0] e;
    } vec_t;
    vec_t tbl [7];

    moa_8x8_sum_checker #(.LATENCY(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
        .x4(x[4]), .x5(x[5]), .x6(x[6]), .x7(x[7]),
        .summ(summ), .busy(busy), .chk_valid(chk_valid), .mismatch(mismatch),
        .exp_summ(exp_summ), .got_summ(got_summ), .err_sticky(err_sticky),
        .chk_cnt(chk_cnt), .err_cnt(err_cnt)
    );

    moa_8x8_sum_checker #(.LATENCY(1), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid2),
        .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
        .x4(x[4]), .x5(x[5]), .x6(x[6]), .x7(x[7]),
        .summ(11'd0), .busy(busy2), .chk_valid(chk_valid2), .mismatch(mismatch2),
        .exp_summ(exp_summ2), .got_summ(got_summ2), .err_sticky(err_sticky2),
        .chk_cnt(chk_cnt2), .err_cnt(err_cnt2)
    );

    // Ideal 3-cycle adder tree with an optional additive fault
    assign sum_w = 11'(x[0]) + 11'(x[1]) + 11'(x[2]) + 11'(x[3])
                 + 11'(x[4]) + 11'(x[5]) + 11'(x[6]) + 11'(x[7]);
    always @(posedge clk) begin
        p0 <= sum_w + inj;
        p1 <= p0;
        p2 <= p1;
    end
    assign summ = p2;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] xs, input logic [10:0] d);
        in_valid = v;
        inj      = d;
        for (int i = 0; i < 8; i++) x[i] = xs[i*8 +: 8];
    endtask

    task automatic expect_cmp(input logic [10:0] e, input logic [10:0] g);
        expq.push_back('{e: e, g: g, m: (e != g)});
    endtask

    // Advance one cycle; score any comparison reported by the main instance
    task automatic step();
        exp_t ex;
        @(negedge clk);
        if (chk_valid) begin
            npulse++;
            if (mismatch) nmis++;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_chk_valid: got chk_valid=1 (exp_summ=%0d) required 0", exp_summ);
            end else begin
                ex = expq.pop_front();
                check("exp_summ", exp_summ, ex.e);
                check("got_summ", got_summ, ex.g);
                check("mismatch", mismatch, ex.m);
            end
        end
    endtask

    function automatic logic [63:0] cvec(input int c);
        logic [7:0] b;
        b = 8'(c);
        return {b + 8'd1, b + 8'd2, b + 8'd3, b + 8'd4,
                b + 8'd4, b + 8'd3, b + 8'd2, b + 8'd1};
    endfunction

    initial begin
        int n0;
        int m0;

        tbl[0] = '{xs: 64'h0000000000000000, e: 11'd0};
        tbl[1] = '{xs: 64'hFFFFFFFFFFFFFFFF, e: 11'h7F8};
        tbl[2] = '{xs: 64'h0807060504030201, e: 11'd36};
        tbl[3] = '{xs: 64'h0102040810204080, e: 11'd255};
        tbl[4] = '{xs: 64'h01000000000000FF, e: 11'd256};
        tbl[5] = '{xs: 64'h6464646464646464, e: 11'd800};
        tbl[6] = '{xs: 64'hFF00FF00FF00FF00, e: 11'd1020};

        rst_n = 1'b0; clr = 1'b0; in_valid2 = 1'b0;
        drive(1'b0, 64'h0, 11'd0);
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_chk_valid", chk_valid, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_exp_summ", exp_summ, 0);
        check("rst_got_summ", got_summ, 0);
        check("rst_err_sticky", err_sticky, 0);
        check("rst_chk_cnt", chk_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_chk_cnt2", chk_cnt2, 0);
        rst_n = 1'b1;
        step();

        // 100 back-to-back counter vectors, sum = 8c+20
        n0 = npulse;
        for (int c = 0; c < 100; c++) begin
            drive(1'b1, cvec(c), 11'd0);
            expect_cmp(11'(8*c + 20), 11'(8*c + 20));
            step();
            if (c == 0) check("busy_after_first_valid", busy, 1);
        end
        drive(1'b0, 64'h0, 11'd0);
        repeat (3) step();
        check("stream_pulses", npulse - n0, 100);
        check("stream_chk_cnt", chk_cnt, 100);
        check("stream_err_cnt", err_cnt, 0);
        check("stream_err_sticky", err_sticky, 0);
        check("stream_busy_drop", busy, 0);
        check("stream_queue_empty", expq.size(), 0);

        // Table of isolated vectors, including the extremes
        for (int i = 0; i < 7; i++) begin
            n0 = npulse;
            drive(1'b1, tbl[i].xs, 11'd0);
            expect_cmp(tbl[i].e, tbl[i].e);
            step();
            drive(1'b0, 64'h0, 11'd0);
            repeat (3) step();
            check("tbl_pulse", npulse - n0, 1);
            check("tbl_busy_drop", busy, 0);
        end

        // clr with in_valid while 3 tags in flight
        drive(1'b1, cvec(1), 11'd0); step();
        drive(1'b1, cvec(2), 11'd0); step();
        drive(1'b1, cvec(3), 11'd0); step();
        clr = 1'b1;
        drive(1'b1, cvec(4), 11'd0); step();
        clr = 1'b0;
        drive(1'b0, 64'h0, 11'd0);
        n0 = npulse;
        repeat (5) step();
        check("clr_no_cmp", npulse - n0, 0);
        check("clr_chk_cnt", chk_cnt, 0);
        check("clr_err_cnt", err_cnt, 0);
        check("clr_busy", busy, 0);
        check("clr_exp_summ", exp_summ, 0);
        check("clr_got_summ", got_summ, 0);
        n0 = npulse;
        drive(1'b1, cvec(5), 11'd0);
        expect_cmp(11'd60, 11'd60);
        step();
        drive(1'b0, 64'h0, 11'd0);
        repeat (2) step();
        check("lat_no_early_cmp", npulse - n0, 0);
        step();
        check("lat_cmp_on_time", npulse - n0, 1);
        check("lat_chk_cnt", chk_cnt, 1);

`ifndef MOA_CHK_HALT_EN
        // Single +1 fault at c=10: one mismatch pulse, then sticky holds
        clr = 1'b1; step(); clr = 1'b0;
        m0 = nmis;
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, cvec(c), (c == 10) ? 11'd1 : 11'd0);
            expect_cmp(11'(8*c + 20), 11'(8*c + 20 + ((c == 10) ? 1 : 0)));
            step();
        end
        drive(1'b0, 64'h0, 11'd0);
        repeat (3) step();
        check("fault_mis_pulses", nmis - m0, 1);
        check("fault_err_cnt", err_cnt, 1);
        check("fault_chk_cnt", chk_cnt, 20);
        repeat (4) step();
        check("fault_sticky_held", err_sticky, 1);
`else
        // Fault at the 5th result halts and captures the failing pair
        clr = 1'b1; step(); clr = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, cvec(c), (c == 4) ? 11'd1 : 11'd0);
            if (c < 5) expect_cmp(11'(8*c + 20), 11'(8*c + 20 + ((c == 4) ? 1 : 0)));
            step();
        end
        repeat (3) step();
        drive(1'b0, 64'h0, 11'd0);
        repeat (6) step();
        check("halt_chk_cnt", chk_cnt, 5);
        check("halt_err_cnt", err_cnt, 1);
        check("halt_busy", busy, 1);
        check("halt_sticky", err_sticky, 1);
        check("halt_exp_summ", exp_summ, 52);
        check("halt_got_summ", got_summ, 53);
        check("halt_queue_empty", expq.size(), 0);
        clr = 1'b1; step(); clr = 1'b0;
        step();
        check("halt_clr_busy", busy, 0);
        check("halt_clr_chk_cnt", chk_cnt, 0);
`endif

        // Asynchronous reset mid-stream drops in-flight tags
        drive(1'b1, cvec(7), 11'd0); step();
        drive(1'b1, cvec(8), 11'd0); step();
        drive(1'b1, cvec(9), 11'd0); step();
        drive(1'b0, 64'h0, 11'd0);
        #2 rst_n = 1'b0;
        #1 check("arst_busy_async", busy, 0);
        #3 rst_n = 1'b1;
        n0 = npulse;
        repeat (6) step();
        check("arst_no_cmp", npulse - n0, 0);
        check("arst_chk_cnt", chk_cnt, 0);

        // Saturating counters on the CNT_W=4 instance, summ stuck at 0
        drive(1'b0, 64'h0101010101010101, 11'd0);
        for (int i = 0; i < 20; i++) begin
            in_valid2 = 1'b1;
            step();
        end
        in_valid2 = 1'b0;
        repeat (3) step();
`ifndef MOA_CHK_HALT_EN
        check("sat_chk_cnt2", chk_cnt2, 15);
        check("sat_err_cnt2", err_cnt2, 15);
        check("sat_busy2", busy2, 0);
`else
        check("sat_chk_cnt2", chk_cnt2, 1);
        check("sat_err_cnt2", err_cnt2, 1);
        check("sat_busy2", busy2, 1);
`endif
        check("sat_sticky2", err_sticky2, 1);
        check("sat_exp_summ2", exp_summ2, 8);
        check("sat_got_summ2", got_summ2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
